// File: rtl/seq_generator.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and shifts it out
// MSB-first, repeating it repeat_cnt times with an optional idle gap between frames.
module seq_generator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] pat_reg, pat_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [CNT_W-1:0] left_reg, left_next;
    logic [CNT_W-1:0] sent_reg, sent_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] idx_dec;
    logic             x_reg, x_next;
    logic             x_valid_reg, x_valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    assign idx_dec = idx_reg - IDX_W'(1);

    // Outputs are computed for the state being entered, so every output is a flop.
    always_comb begin
        state_next   = state_reg;
        pat_next     = pat_reg;
        gap_next     = gap_reg;
        gap_cnt_next = gap_cnt_reg;
        left_next    = left_reg;
        sent_next    = sent_reg;
        idx_next     = idx_reg;
        x_next       = 1'b0;
        x_valid_next = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pat_next     = pattern_in;
                    gap_next     = gap_len;
                    left_next    = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
                    sent_next    = '0;
                    idx_next     = IDX_TOP;
                    state_next   = ST_SEND;
                    x_next       = pattern_in[WIDTH-1];
                    x_valid_next = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (idx_reg == '0) begin
                    if (sent_reg != CNT_MAX) sent_next = sent_reg + CNT_W'(1);
                    left_next = left_reg - CNT_W'(1);
                    if (left_reg > CNT_W'(1)) begin
                        busy_next = 1'b1;
                        if (gap_reg != '0) begin
                            state_next   = ST_GAP;
                            gap_cnt_next = gap_reg;
                        end else begin
                            idx_next     = IDX_TOP;
                            x_next       = pat_reg[WIDTH-1];
                            x_valid_next = 1'b1;
                        end
                    end else begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                end else begin
                    idx_next     = idx_dec;
                    x_next       = pat_reg[idx_dec];
                    x_valid_next = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt_reg <= GAP_W'(1)) begin
                    state_next   = ST_SEND;
                    idx_next     = IDX_TOP;
                    x_next       = pat_reg[WIDTH-1];
                    x_valid_next = 1'b1;
                    busy_next    = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                    busy_next    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            pat_reg     <= '0;
            gap_reg     <= '0;
            gap_cnt_reg <= '0;
            left_reg    <= '0;
            sent_reg    <= '0;
            idx_reg     <= '0;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pat_reg     <= pat_next;
            gap_reg     <= gap_next;
            gap_cnt_reg <= gap_cnt_next;
            left_reg    <= left_next;
            sent_reg    <= sent_next;
            idx_reg     <= idx_next;
            x_reg       <= x_next;
            x_valid_reg <= x_valid_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign x           = x_reg;
    assign x_valid     = x_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign frames_sent = sent_reg;

endmodule

// File: doc/seq_generator.md
Name: seq_generator

Overview:
- Serial pattern transmitter that produces the single-bit stream consumed by seq_detector.
- Latches a WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional idle gap between frames.
- Used as a stimulus/traffic source for detector power-estimation runs, with known toggle activity.

Parameters:
- WIDTH, 4, pattern length in bits (valid range 2..16).
- CNT_W, 8, width of the repeat count and of the frames_sent counter.
- GAP_W, 4, width of the inter-frame gap length.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset: asynchronous, active-low (0 = reset).
- start  input  1  request to begin transmission; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE.
- pattern_in  input  WIDTH  pattern to transmit, latched on accepted start.
- repeat_cnt  input  CNT_W  number of frames to send, latched on accepted start.
- gap_len  input  GAP_W  idle cycles between frames, latched on accepted start.
- x  output  1  serial data bit (drives the detector's x).
- x_valid  output  1  high while x carries a pattern bit.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse after the final bit of the final frame.
- frames_sent  output  CNT_W  frames fully transmitted since the last accepted start.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - x=0, x_valid=0, busy=0, done=0, frames_sent=0.
  - Latched registers are cleared.
  - Effect is immediate, including mid-frame; no done pulse is generated.
- All outputs are registered.
- States and transitions:
  - IDLE: x=0, x_valid=0, busy=0. When start=1 at edge k:
    - Latch pattern_in, gap_len and repeat_cnt, with repeat_cnt=0 treated as 1.
    - Clear frames_sent, set bit index to WIDTH-1, go to SEND.
    - After edge k: x=pattern[WIDTH-1], x_valid=1, busy=1. Latency from start sample to first bit is 1 cycle.
  - SEND: each cycle x=pattern[idx], x_valid=1, idx decrements.
    - On the edge that consumes idx=0, frames_sent increments (saturating at 2^CNT_W-1).
    - If frames remain and gap>0: go to GAP for exactly gap cycles, with x=0 and x_valid=0.
    - If frames remain and gap=0: reload idx=WIDTH-1 and stay in SEND, giving back-to-back frames with no bubble.
    - If no frames remain: go to DONE.
  - GAP: down-counts the gap; when it expires, reload idx=WIDTH-1 and go to SEND.
  - DONE: one cycle with done=1, busy=0, x=0, x_valid=0; then IDLE unconditionally.
- start while busy or in DONE is ignored; it is not queued.
- start held high continuously re-triggers a new run from IDLE, i.e. one cycle after the done cycle.
- abort=1 in SEND or GAP:
  - Next cycle is IDLE with x=0 and x_valid=0.
  - No done pulse; frames_sent holds its value.
- abort has priority over start on the same edge; abort in IDLE has no effect.
- Timing per run (N frames, gap G):
  - x_valid high for N*WIDTH cycles.
  - busy high for N*WIDTH + (N-1)*G cycles.
  - done occurs exactly one cycle after the last valid bit.
- Inputs pattern_in, repeat_cnt and gap_len may change freely after start is accepted without affecting the run.

Test Plan:
- Reset then single frame:
  - Stimulus: rst low for 10 ns, then pattern_in=4'b1101, repeat_cnt=1, gap_len=0, start pulse.
  - Required: x=1,1,0,1 on 4 consecutive cycles with x_valid=1; done on cycle 5; frames_sent=1.
- Repeat with gap:
  - Stimulus: pattern 4'b0110, repeat_cnt=3, gap_len=2.
  - Required: 0110, 00 (x_valid=0), 0110, 00, 0110, then done; busy high for exactly 16 cycles; frames_sent=3.
- Back-to-back and repeat_cnt=0:
  - Stimulus: pattern 4'b1011, repeat_cnt=2, gap=0.
  - Required: 8 contiguous valid bits 10111011, done at cycle 9.
  - Stimulus: repeat_cnt=0.
  - Required: exactly one frame is sent.
- Abort and ignored start:
  - Stimulus: abort asserted on the 2nd bit of frame 2 of a 3-frame run.
  - Required: IDLE next cycle, no done, frames_sent=1.
  - Stimulus: start pulsed mid-run.
  - Required: no effect on the stream.
- Async reset mid-frame:
  - Stimulus: rst driven low between clock edges during SEND.
  - Required: x, x_valid, busy and frames_sent go to 0 before the next edge.
  - Stimulus: after release, issue start.
  - Required: a clean frame from the MSB.
- Loopback into seq_detector:
  - Stimulus: drive the detector's x from this block's x, with the target sequence embedded in a repeated pattern.
  - Required: detector z pulses once per occurrence, at cycles predicted from the WIDTH/gap timing above.
